// File: rtl/enc_seq_ctrl.sv
// Sequencer for the index -> Gray/one-hot code encoder; emits a programmed run of encoded words.
// Optional abort input is enabled with `define ENC_SEQ_CTRL_ABORT_EN.
module enc_seq_ctrl #(
  parameter int unsigned IDX_W = 3,
  parameter int unsigned CNT_W = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      mode,
  input  logic [IDX_W-1:0]          start_idx,
  input  logic [CNT_W-1:0]          num_steps,
`ifdef ENC_SEQ_CTRL_ABORT_EN
  input  logic                      abort,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IDX_W-1:0]          out_idx,
  output logic [(2**IDX_W)-2:0]     out_code,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned CodeW = (2 ** IDX_W) - 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   steps_q, steps_d;
  logic               mode_q, mode_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CodeW-1:0]   code_q, code_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic [IDX_W-1:0]   idx_inc;
  logic               abort_req;

  // Gray keeps the low IDX_W bits; one-hot maps index 0 to the all-zero word.
  function automatic logic [CodeW-1:0] encode(input logic m, input logic [IDX_W-1:0] i);
    logic [CodeW-1:0] r;
    r = '0;
    if (m) begin
      r[IDX_W-1:0] = i ^ (i >> 1);
    end else if (i != '0) begin
      r = CodeW'(1) << (i - 1'b1);
    end
    return r;
  endfunction

`ifdef ENC_SEQ_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign cnt_inc = cnt_q + 1'b1;
  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    steps_d = steps_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    code_d  = code_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        if (start) begin
          mode_d  = mode;
          steps_d = num_steps;
          cnt_d   = '0;
          busy_d  = 1'b1;
          if (num_steps != '0) begin
            state_d = StRun;
            idx_d   = start_idx;
            code_d  = encode(mode, start_idx);
            valid_d = 1'b1;
          end else begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end

      StRun: begin
        if (abort_req) begin
          // Abort beats a simultaneous handshake: the word counts as unsent.
          state_d = StIdle;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (out_ready) begin
          cnt_d = cnt_inc;
          if (cnt_inc == steps_q) begin
            state_d = StDone;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d  = idx_inc;
            code_d = encode(mode_q, idx_inc);
          end
        end
      end

      StDone: begin
        state_d = StIdle;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      steps_q <= '0;
      mode_q  <= 1'b0;
      idx_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      steps_q <= steps_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_code  = code_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/enc_seq_ctrl.md
Name: enc_seq_ctrl

Overview:
- Sequencer for the 3-bit code encoder datapath (binary index -> Gray code or one-hot code).
- On a start command, steps a 3-bit index through a programmed number of consecutive values from a programmed start index.
- Presents each index and its encoded word on a valid/ready output stream, then signals completion.
- Sits between a configuration/control master and any consumer of encoded code words, such as display drivers or test pattern sinks.

Parameters:
- IDX_W, 3: index width; encoded word width is 2**IDX_W - 1 (7 at default).
- CNT_W, 4: width of num_steps and of the internal step counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  start request; sampled only in IDLE.
- mode  input  1  1 = Gray encoding, 0 = one-hot encoding; latched on start.
- start_idx  input  IDX_W  first index; latched on start.
- num_steps  input  CNT_W  number of words to emit (0..15); latched on start.
- out_valid  output  1  out_code/out_idx hold a valid word.
- out_ready  input  1  consumer accepts the word when high together with out_valid.
- out_idx  output  IDX_W  current binary index.
- out_code  output  7  encoded word for out_idx.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse at end of sequence.

Behaviour:
- Reset: one clock, clk; asynchronous active-low reset rst_n. Reset forces state=IDLE, out_valid=0, out_idx=0, out_code=0, busy=0, done=0, step counter=0, latched mode/num_steps=0. Reset asserted mid-sequence aborts immediately, with no done pulse.
- All outputs are registered.
- Encoding, from index i:
  - Gray mode: out_code = {4'b0, i ^ (i>>1)}.
  - One-hot mode: i=0 -> 7'b0000000; otherwise out_code = 7'b1 << (i-1).
  - Example: i=3 gives 7'b0000010 in Gray mode and 7'b0000100 in one-hot mode.
- State IDLE:
  - busy=0, out_valid=0.
  - start=1 latches mode, start_idx and num_steps, and clears the counter.
  - If num_steps != 0: go to RUN, load out_idx=start_idx and its out_code, and set out_valid=1 on the same edge. The first word is visible the cycle after start is sampled.
  - If num_steps == 0: go to DONE; out_valid never asserts.
- State RUN:
  - out_valid=1.
  - While out_ready=0, out_idx and out_code are held stable (no change under backpressure).
  - Handshake (out_valid & out_ready) at an edge increments the counter.
  - If the incremented count equals num_steps: go to DONE and deassert out_valid.
  - Otherwise: out_idx advances by 1 modulo 2**IDX_W (7 wraps to 0), out_code is updated to match, and out_valid stays 1. One word per cycle is possible with out_ready held high.
  - num_steps > 8 revisits indices after the wrap.
- State DONE:
  - Lasts exactly one cycle: done=1, busy=1, out_valid=0.
  - Then returns to IDLE.
  - start is ignored in DONE and RUN.
- Inputs mode, start_idx and num_steps are ignored except at the accepting start edge.
- done and out_valid are never high in the same cycle.

Optional Feature:
- Macro: ENC_SEQ_CTRL_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 sampled in RUN returns the block to IDLE on that edge: out_valid=0, busy=0, no done pulse.
  - If abort and a handshake occur on the same edge, abort wins and the word is treated as not sent.
  - abort is ignored in IDLE and DONE.
- Not defined: no abort port; every sequence runs to completion or until reset.

Test Plan:
- Gray, start_idx=0, num_steps=4, out_ready=1 -> out_code 0x00,0x01,0x03,0x02 on consecutive cycles, starting one cycle after start; done pulses the cycle after the last word; busy drops with IDLE.
- One-hot, start_idx=0, num_steps=8, out_ready=1 -> out_code 0x00,0x01,0x02,0x04,0x08,0x10,0x20,0x40; out_idx 0..7; exactly one done pulse.
- Gray, start_idx=6, num_steps=3, out_ready=1 -> out_idx 6,7,0 with out_code 0x05,0x04,0x00 (wrap).
- Backpressure: one-hot, start_idx=2, num_steps=2, out_ready low for 3 cycles then high -> out_code held at 0x02 for 4 cycles, then 0x04 for one cycle, then done.
- num_steps=0 with start -> out_valid never asserts; done=1 exactly one cycle after start is sampled. A second start during RUN is ignored (word count unchanged).
- rst_n low mid-RUN -> outputs at reset values immediately (asynchronously), no done pulse. If ENC_SEQ_CTRL_ABORT_EN is defined: abort on the 2nd word returns to IDLE the next cycle, with no done pulse.
